// File: rtl/risc_pkg.sv
// Shared encodings for the data RAM arbiter: FSM states, grant owner, host word geometry.
package risc_pkg;
  typedef enum logic [2:0] {
    IDLE,
    H_COLLECT,
    H_WRITE,
    H_CAPTURE,
    H_STREAM
  } arb_state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_HOST
  } grant_e;

  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data RAM between the CPU (word access) and a byte-serial host
// port; the host assembles/serialises whole words while the CPU is held off.
module data_mem_arbiter
  import risc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_byte_in,
  input  logic              host_byte_valid,
  output logic              host_busy,
  output logic [7:0]        host_byte_out,
  output logic              host_byte_out_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              rvalid_q, rvalid_d;
  logic              cpu_win;
  logic              host_win;

  always_comb begin
    state_d             = state_q;
    last_d              = last_q;
    cnt_d               = cnt_q;
    addr_d              = addr_q;
    word_d              = word_q;
    cpu_gnt             = 1'b0;
    host_busy           = (state_q != IDLE);
    host_byte_out       = '0;
    host_byte_out_valid = 1'b0;
    mem_we              = 1'b0;
    mem_addr            = cpu_addr;
    mem_wdata           = cpu_wdata;
    // CPU loses a tie only if it was the last one served
    cpu_win             = cpu_req && (!host_req || last_q == GNT_HOST);
    host_win            = host_req && !cpu_win;
    unique case (state_q)
      IDLE: begin
        if (cpu_win) begin
          cpu_gnt = 1'b1;
          mem_we  = cpu_we;
          last_d  = GNT_CPU;
        end else if (host_win) begin
          host_busy = 1'b1;
          last_d    = GNT_HOST;
          addr_d    = host_addr;
          cnt_d     = '0;
          if (host_we) begin
            word_d  = '0;
            state_d = H_COLLECT;
          end else begin
            mem_addr = host_addr;
            state_d  = H_CAPTURE;
          end
        end
      end
      H_COLLECT: begin
        if (host_byte_valid) begin
          word_d[{cnt_q, 3'b000} +: 8] = host_byte_in;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BYTE) state_d = H_WRITE;
        end
      end
      H_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = word_q;
        state_d   = IDLE;
      end
      H_CAPTURE: begin
        word_d  = mem_rdata;
        cnt_d   = '0;
        state_d = H_STREAM;
      end
      H_STREAM: begin
        host_byte_out_valid = 1'b1;
        host_byte_out       = word_q[7:0];
        word_d              = word_q >> 8;
        cnt_d               = cnt_q + 2'd1;
        if (cnt_q == LAST_BYTE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset is synchronous, so the outputs are forced quiet during the reset cycle itself
    if (rst) begin
      cpu_gnt             = 1'b0;
      host_busy           = 1'b0;
      host_byte_out       = '0;
      host_byte_out_valid = 1'b0;
      mem_we              = 1'b0;
    end
    rvalid_d = cpu_gnt && !cpu_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= GNT_HOST;
      cnt_q    <= '0;
      addr_q   <= '0;
      word_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rvalid_q ? mem_rdata : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: transaction table, directed corner sequences, random traffic vs a word-level memory model.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [4:0]  cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_req = 0, host_we = 0;
  logic [4:0]  host_addr = 0;
  logic [7:0]  host_byte_in = 0;
  logic        host_byte_valid = 0;
  logic        host_busy;
  logic [7:0]  host_byte_out;
  logic        host_byte_out_valid;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_byte_in(host_byte_in), .host_byte_valid(host_byte_valid),
    .host_busy(host_busy), .host_byte_out(host_byte_out), .host_byte_out_valid(host_byte_out_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM with registered read
  logic [31:0] ram [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  logic [31:0] model [32];
  int checks = 0, errors = 0;

  typedef struct {
    int          kind;  // 0 cpu write, 1 cpu read, 2 host write, 3 host read
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(string name);
    int n = 0;
    @(negedge clk);
    while (!host_busy && n < 60) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!host_busy) chk(name, 0, 1);
  endtask

  task automatic cpu_access(input logic we, input logic [4:0] addr, input logic [31:0] data,
                            output logic [31:0] rd);
    int n = 0;
    rd = '0;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    @(negedge clk);
    while (!cpu_gnt && n < 60) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!cpu_gnt) begin
      chk("cpu_gnt_timeout", 0, 1);
      cpu_req = 0;
      step();
    end else begin
      chk("cpu_mem_we", 32'(mem_we), 32'(we));
      chk("cpu_mem_addr", 32'(mem_addr), 32'(addr));
      if (we) chk("cpu_mem_wdata", mem_wdata, data);
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(!we));
      rd = cpu_rdata;
      step();
    end
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [31:0] data);
    host_req = 1; host_we = 1; host_addr = addr;
    wait_busy("hw_grant_timeout");
    chk("hw_grant_no_we", 32'(mem_we), 0);
    step();
    host_req = 0;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) step();
      host_byte_in = data[8*k +: 8];
      host_byte_valid = 1;
      @(negedge clk);
      chk("hw_collect_no_we", 32'(mem_we), 0);
      step();
      host_byte_valid = 0;
    end
    @(negedge clk);
    chk("hw_mem_we", 32'(mem_we), 1);
    chk("hw_mem_addr", 32'(mem_addr), 32'(addr));
    chk("hw_mem_wdata", mem_wdata, data);
    step();
    @(negedge clk);
    chk("hw_single_we", 32'(mem_we), 0);
    chk("hw_idle_busy", 32'(host_busy), 0);
    step();
  endtask

  task automatic host_read(input logic [4:0] addr, input logic [31:0] exp);
    host_req = 1; host_we = 0; host_addr = addr;
    wait_busy("hr_grant_timeout");
    chk("hr_grant_we", 32'(mem_we), 0);
    chk("hr_grant_addr", 32'(mem_addr), 32'(addr));
    step();
    host_req = 0;
    @(negedge clk);
    chk("hr_capture_valid", 32'(host_byte_out_valid), 0);
    chk("hr_capture_busy", 32'(host_busy), 1);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hr_stream_valid", 32'(host_byte_out_valid), 1);
      chk("hr_stream_byte", 32'(host_byte_out), 32'(exp[8*k +: 8]));
      chk("hr_stream_busy", 32'(host_busy), 1);
      step();
    end
    @(negedge clk);
    chk("hr_end_valid", 32'(host_byte_out_valid), 0);
    chk("hr_end_busy", 32'(host_busy), 0);
    step();
  endtask

  initial begin
    logic [31:0] rd;
    int          grants [$];
    logic        prev_busy;
    int          n, bad;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    tbl[0]  = '{0, 5'd3,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 5'd3,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{2, 5'd5,  32'hDEADBEEF, 32'h0};
    tbl[3]  = '{1, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[4]  = '{3, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[5]  = '{2, 5'd7,  32'h12345678, 32'h0};
    tbl[6]  = '{3, 5'd7,  32'h0,        32'h12345678};
    tbl[7]  = '{1, 5'd7,  32'h0,        32'h12345678};
    tbl[8]  = '{0, 5'd0,  32'hA5A55A5A, 32'h0};
    tbl[9]  = '{3, 5'd0,  32'h0,        32'hA5A55A5A};
    tbl[10] = '{2, 5'd31, 32'h80000001, 32'h0};
    tbl[11] = '{1, 5'd31, 32'h0,        32'h80000001};

    // reset with both requesters active
    cpu_req = 1; host_req = 1; cpu_we = 0; host_we = 0;
    step(); step();
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_busy", 32'(host_busy), 0);
    chk("rst_byte_out", 32'(host_byte_out), 0);
    chk("rst_byte_out_valid", 32'(host_byte_out_valid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    step();
    rst = 0;

    // contention straight out of reset: CPU first, then alternate
    prev_busy = 0;
    n = 0;
    while (grants.size() < 4 && n < 200) begin
      @(negedge clk);
      if (cpu_gnt) grants.push_back(0);
      else if (host_busy && !prev_busy) grants.push_back(1);
      prev_busy = host_busy;
      step();
      n++;
    end
    cpu_req = 0; host_req = 0;
    repeat (8) step();
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("rr_order", grants[i], i % 2);

    for (int i = 0; i < 12; i++) begin
      case (tbl[i].kind)
        0: begin cpu_access(1, tbl[i].addr, tbl[i].data, rd); model[tbl[i].addr] = tbl[i].data; end
        1: begin cpu_access(0, tbl[i].addr, 0, rd); chk("tbl_cpu_rdata", rd, tbl[i].exp); end
        2: begin host_write(tbl[i].addr, tbl[i].data); model[tbl[i].addr] = tbl[i].data; end
        default: host_read(tbl[i].addr, tbl[i].exp);
      endcase
    end

    // reset after two host bytes: word abandoned, RAM untouched
    cpu_access(1, 5'd9, 32'h11223344, rd);
    model[9] = 32'h11223344;
    host_req = 1; host_we = 1; host_addr = 5'd9;
    wait_busy("abort_grant_timeout");
    step();
    host_req = 0;
    for (int k = 0; k < 2; k++) begin
      host_byte_in = 8'hF0 + 8'(k); host_byte_valid = 1; step();
    end
    host_byte_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_rst_we", 32'(mem_we), 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("abort_idle_busy", 32'(host_busy), 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      host_byte_in = 8'hE0 + 8'(k); host_byte_valid = 1;
      @(negedge clk);
      if (mem_we || host_busy) bad++;
      step();
    end
    host_byte_valid = 0;
    chk("abort_stray_bytes", bad, 0);
    cpu_access(0, 5'd9, 0, rd);
    chk("abort_ram_kept", rd, 32'h11223344);

    // CPU request arriving during host byte collection
    host_req = 1; host_we = 1; host_addr = 5'd12;
    wait_busy("stall_grant_timeout");
    step();
    host_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd12;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_gnt) bad++;
      step();
      host_byte_in = 8'(32'hCAFEF00D >> (8 * k)); host_byte_valid = 1;
      @(negedge clk);
      if (cpu_gnt) bad++;
      step();
      host_byte_valid = 0;
    end
    @(negedge clk);
    chk("stall_hwrite_gnt", 32'(cpu_gnt), 0);
    chk("stall_hwrite_we", 32'(mem_we), 1);
    chk("stall_collect_gnt", bad, 0);
    step();
    @(negedge clk);
    chk("stall_gnt_after", 32'(cpu_gnt), 1);
    step();
    cpu_req = 0;
    @(negedge clk);
    chk("stall_rvalid", 32'(cpu_rvalid), 1);
    chk("stall_rdata", cpu_rdata, 32'hCAFEF00D);
    model[12] = 32'hCAFEF00D;
    step();

    // random traffic against the word-level model
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [4:0]  a;
      logic [31:0] d;
      kind = $urandom_range(0, 3);
      a    = 5'($urandom_range(0, 31));
      d    = $urandom;
      case (kind)
        0: begin cpu_access(1, a, d, rd); model[a] = d; end
        1: begin cpu_access(0, a, 0, rd); chk("rnd_cpu_rdata", rd, model[a]); end
        2: begin host_write(a, d); model[a] = d; end
        default: host_read(a, model[a]);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
